// File: rtl/clap_sequencer_if.sv
// clap_sequencer_if: sound-sensor input and servo-stage outputs of the clap sequencer.
interface clap_sequencer_if;
    logic       MIC;
    logic       cont_aplausos;
    logic [1:0] lado;
    logic       clap_pulse;
    logic       busy;
    modport master (output MIC, input cont_aplausos, lado, clap_pulse, busy);
    modport slave  (input MIC, output cont_aplausos, lado, clap_pulse, busy);
endinterface

// File: rtl/clap_sequencer.sv
// clap_sequencer: qualifies claps from MIC, counts them in a window and commits servo enable/position.
// Optional inactivity auto-off is enabled by defining CLAP_AUTO_OFF_EN.
module clap_sequencer #(
    parameter int MIN_HIGH_CYC = 50_000,
    parameter int BLANK_CYC    = 5_000_000,
    parameter int WINDOW_CYC   = 50_000_000,
    parameter int AUTO_OFF_CYC = 500_000_000
) (
    input logic CLK,
    input logic RST_N,
    clap_sequencer_if.slave bus
);
    localparam int QW = $clog2(MIN_HIGH_CYC + 1);
    localparam int BW = $clog2(BLANK_CYC + 1);
    localparam int WW = $clog2(WINDOW_CYC + 1);
    localparam logic [QW-1:0] Q_LAST = QW'(MIN_HIGH_CYC - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLANK_CYC - 1);
    localparam logic [WW-1:0] W_LAST = WW'(WINDOW_CYC - 1);

    if (WINDOW_CYC <= BLANK_CYC + MIN_HIGH_CYC || AUTO_OFF_CYC < 1) begin : g_bad_cfg
        $error("clap_sequencer: WINDOW_CYC must exceed BLANK_CYC + MIN_HIGH_CYC");
    end

    typedef enum logic [2:0] {IDLE, QUALIFY, BLANK, WAIT, COMMIT} state_t;
    state_t state, state_nx;
    logic [1:0]    sync;
    logic [QW-1:0] qcnt;
    logic [BW-1:0] bcnt;
    logic [WW-1:0] wcnt;
    logic [2:0]    n;
    logic          mic_s, in_seq, expire, accept, timeout;

    assign mic_s  = sync[1];
    assign in_seq = state == QUALIFY || state == BLANK || state == WAIT;
    // Window expiry overrides any clap activity in the same cycle.
    assign expire = in_seq && n != 3'd0 && wcnt == W_LAST;
    assign accept = state == QUALIFY && mic_s && qcnt == Q_LAST && !expire;

    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (expire) state_nx = COMMIT;
        else case (state)
            IDLE, WAIT: state_nx = mic_s ? QUALIFY : state;
            QUALIFY:    state_nx = !mic_s ? (n == 3'd0 ? IDLE : WAIT) : (accept ? BLANK : QUALIFY);
            BLANK:      state_nx = bcnt == B_LAST ? WAIT : BLANK;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = state != IDLE;
        bus.clap_pulse = accept;
    end

`ifdef CLAP_AUTO_OFF_EN
    logic [28:0] ao_cnt;
    assign timeout = bus.cont_aplausos && ao_cnt == 29'(AUTO_OFF_CYC - 1);
    always_ff @(posedge CLK) begin
        if (!RST_N) ao_cnt <= '0;
        else ao_cnt <= accept ? '0 : (bus.cont_aplausos ? ao_cnt + 1'b1 : ao_cnt);
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync              <= '0;
            qcnt              <= '0;
            bcnt              <= '0;
            wcnt              <= '0;
            n                 <= '0;
            bus.cont_aplausos <= 1'b0;
            bus.lado          <= '0;
        end else begin
            sync <= {sync[0], bus.MIC};
            qcnt <= state == QUALIFY ? qcnt + 1'b1 : '0;
            bcnt <= state == BLANK ? bcnt + 1'b1 : '0;
            wcnt <= (accept || !in_seq) ? '0 : wcnt + 1'b1;
            n    <= state == COMMIT ? 3'd0 : ((accept && n != 3'd7) ? n + 3'd1 : n);
            // Five or more claps cancel: drop the enable, keep the last position.
            if (state == COMMIT) begin
                bus.cont_aplausos <= n <= 3'd4;
                if (n <= 3'd4) bus.lado <= n[1:0] - 2'd1;
            end else if (timeout) begin
                bus.cont_aplausos <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_clap_sequencer.sv
// tb_clap_sequencer: randomized and scenario stimulus against a timestamp-based reference model.
module tb_clap_sequencer;
    localparam int MIN    = 4;
    localparam int BLANK  = 20;
    localparam int WINDOW = 100;
    localparam int AUTO   = 500;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    clap_sequencer_if bus();

    clap_sequencer #(
        .MIN_HIGH_CYC(MIN),
        .BLANK_CYC(BLANK),
        .WINDOW_CYC(WINDOW),
        .AUTO_OFF_CYC(AUTO)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    // Model: mode 0 idle, 1 qualifying, 2 blanked, 3 waiting, 4 committing; times are cycle indices.
    int cyc = 0, mode = 0, q_t0 = 0, acc_t = 0, claps = 0, ao = 0;
    logic d1 = 1'b0, d2 = 1'b0, m_cont = 1'b0;
    logic [1:0] m_lado = 2'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic logic m_expire();
        return (mode == 1 || mode == 2 || mode == 3) && claps > 0 && cyc - acc_t == WINDOW;
    endfunction

    function automatic logic m_accept();
        return mode == 1 && d2 && cyc - q_t0 == MIN - 1 && !m_expire();
    endfunction

    task automatic model_step(input logic mic, input logic rst);
        logic ex, ac, to;
        int nm;
        ex = m_expire();
        ac = m_accept();
        to = 1'b0;
`ifdef CLAP_AUTO_OFF_EN
        to = m_cont && ao == AUTO - 1;
`endif
        if (!rst) begin
            d1 = 0; d2 = 0; mode = 0; claps = 0; m_cont = 0; m_lado = 0; ao = 0;
        end else begin
            nm = mode;
            if (ex) nm = 4;
            else if (mode == 0 || mode == 3) begin
                if (d2) begin nm = 1; q_t0 = cyc + 1; end
            end
            else if (mode == 1) nm = !d2 ? (claps > 0 ? 3 : 0) : (ac ? 2 : 1);
            else if (mode == 2) nm = (cyc - acc_t == BLANK) ? 3 : 2;
            else nm = 0;
            ao = ac ? 0 : (m_cont ? ao + 1 : ao);
            if (mode == 4) begin
                if (claps <= 4) begin m_cont = 1; m_lado = 2'(claps - 1); end
                else m_cont = 0;
                claps = 0;
            end else if (to) m_cont = 0;
            if (ac) begin acc_t = cyc; claps = claps < 7 ? claps + 1 : 7; end
            mode = nm; d2 = d1; d1 = mic;
        end
        cyc++;
    endtask

    task automatic tick(input logic mic, input logic rst);
        @(negedge CLK);
        check("cont", bus.cont_aplausos, m_cont);
        check("lado", bus.lado, m_lado);
        check("pulse", bus.clap_pulse, m_accept());
        check("busy", bus.busy, mode != 0);
        if (bus.clap_pulse) pulses++;
        bus.MIC = mic;
        RST_N = rst;
        model_step(mic, rst);
    endtask

    task automatic hold(input logic mic, input int len);
        repeat (len) tick(mic, 1'b1);
    endtask

    initial begin
        bus.MIC = 1'b0;
        repeat (3) tick(1'b0, 1'b0);
        check("reset_busy", bus.busy, 0);
        check("reset_cont", bus.cont_aplausos, 0);
        pulses = 0;
        hold(1, 10); hold(0, 130);
        check("single_pulses", pulses, 1);
        check("single_cont", bus.cont_aplausos, 1);
        check("single_lado", bus.lado, 0);
        pulses = 0;
        repeat (3) begin hold(1, 10); hold(0, 30); end
        hold(0, 120);
        check("three_pulses", pulses, 3);
        check("three_cont", bus.cont_aplausos, 1);
        check("three_lado", bus.lado, 2);
        pulses = 0;
        repeat (5) begin hold(1, 10); hold(0, 30); end
        hold(0, 120);
        check("cancel_pulses", pulses, 5);
        check("cancel_cont", bus.cont_aplausos, 0);
        check("cancel_lado", bus.lado, 2);
        pulses = 0;
        repeat (4) begin hold(1, 3); hold(0, 47); end
        check("glitch_pulses", pulses, 0);
        check("glitch_busy", bus.busy, 0);
        check("glitch_cont", bus.cont_aplausos, 0);
        pulses = 0;
        hold(1, 60); hold(0, 130);
        check("blank_pulses", pulses, 3);
        check("blank_lado", bus.lado, 2);
        check("blank_cont", bus.cont_aplausos, 1);
        pulses = 0;
        hold(1, 10); hold(0, 30); hold(1, 10); hold(0, 30);
        tick(1'b0, 1'b0);
        hold(0, 150);
        check("rst_pulses", pulses, 2);
        check("rst_cont", bus.cont_aplausos, 0);
        check("rst_lado", bus.lado, 0);
        check("rst_busy", bus.busy, 0);
        repeat (40) begin
            if ($urandom_range(0, 19) == 0) tick(1'b0, 1'b0);
            else hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 50)));
        end
        hold(0, 250);
        check("rand_idle", bus.busy, 0);
`ifdef CLAP_AUTO_OFF_EN
        hold(1, 10); hold(0, 700);
        check("auto_off_cont", bus.cont_aplausos, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
